// File: rtl/cordic_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cordic_arbiter
// Description : Round-robin arbiter sharing one CORDIC sine/cosine core
//               between two requesters, with a watchdog on the core.
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_arbiter #(
  parameter int W       = 18,
  parameter int TIMEOUT = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   req_valid,
  input  logic [W-1:0] req_angle0,
  input  logic [W-1:0] req_angle1,
  output logic [1:0]   req_ready,
  output logic         res_valid,
  input  logic         res_ready,
  output logic         res_id,
  output logic [W-1:0] res_cos,
  output logic [W-1:0] res_sin,
  output logic         res_timeout,
  output logic         busy,
  output logic         cordic_init,
  output logic [W-1:0] cordic_angle,
  input  logic         cordic_done,
  input  logic [W-1:0] cordic_cos,
  input  logic [W-1:0] cordic_sin
);

  localparam int                 C_CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_prio;
  logic [C_CNT_W-1:0]  r_cnt;
  logic                w_grant_id;
  logic                w_accept;
  logic                w_done_hit;
  logic                w_timeout_hit;

  // r_prio names the requester that wins when both are valid
  always_comb begin
    w_grant_id = 1'b0;
    case (req_valid)
      2'b01:   w_grant_id = 1'b0;
      2'b10:   w_grant_id = 1'b1;
      2'b11:   w_grant_id = r_prio;
      default: w_grant_id = 1'b0;
    endcase
  end

  assign w_accept      = (r_state == S_IDLE) && (|req_valid);
  assign req_ready     = w_accept ? (w_grant_id ? 2'b10 : 2'b01) : 2'b00;
  assign w_done_hit    = (r_state == S_WAIT) && cordic_done;
  assign w_timeout_hit = (r_state == S_WAIT) && !cordic_done && (r_cnt == C_CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    cordic_init = 1'b0;
    res_valid   = 1'b0;
    busy        = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (w_accept) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cordic_init = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (w_done_hit || w_timeout_hit) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        res_valid = 1'b1;
        if (res_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio       <= 1'b0;
      cordic_angle <= '0;
      res_id       <= 1'b0;
    end else if (w_accept) begin
      r_prio       <= ~w_grant_id;
      cordic_angle <= w_grant_id ? req_angle1 : req_angle0;
      res_id       <= w_grant_id;
    end
  end

  // Counts completed WAIT cycles; the final one either sees done or aborts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_state == S_ISSUE) begin
      r_cnt <= '0;
    end else if ((r_state == S_WAIT) && !w_timeout_hit) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_cos     <= '0;
      res_sin     <= '0;
      res_timeout <= 1'b0;
    end else if (w_done_hit) begin
      res_cos     <= cordic_cos;
      res_sin     <= cordic_sin;
      res_timeout <= 1'b0;
    end else if (w_timeout_hit) begin
      res_cos     <= '0;
      res_sin     <= '0;
      res_timeout <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cordic_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cordic_arbiter
// Description : Scoreboard bench for cordic_arbiter with a behavioural core.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_arbiter;

  localparam int W       = 18;
  localparam int TIMEOUT = 32;
  localparam int NOM_LAT = 17;

  typedef struct {
    logic         id;
    logic [W-1:0] cos_v;
    logic [W-1:0] sin_v;
    logic         to;
    int           due;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   req_valid;
  logic [W-1:0] req_angle0, req_angle1;
  logic [1:0]   req_ready;
  logic         res_valid, res_ready, res_id, res_timeout, busy, cordic_init;
  logic [W-1:0] res_cos, res_sin, cordic_angle;
  logic         cordic_done = 1'b0;
  logic [W-1:0] cordic_cos = '0, cordic_sin = '0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cordic_arbiter #(.W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_angle0(req_angle0), .req_angle1(req_angle1),
    .req_ready(req_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_cos(res_cos), .res_sin(res_sin), .res_timeout(res_timeout),
    .busy(busy), .cordic_init(cordic_init), .cordic_angle(cordic_angle),
    .cordic_done(cordic_done), .cordic_cos(cordic_cos), .cordic_sin(cordic_sin)
  );

  function automatic real ang(input logic [W-1:0] a);
    return $itor($signed(a)) / 65536.0;
  endfunction

  function automatic logic [W-1:0] q16(input real x);
    real s;
    int  v;
    s = x * 65536.0;
    v = (s >= 0.0) ? $rtoi(s + 0.5) : -$rtoi(-s + 0.5);
    return W'(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic near(input string name, input logic [W-1:0] act, input int exp);
    int d;
    checks++;
    d = int'($signed(act)) - exp;
    if (d < 0) d = -d;
    if (d > 64) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d +/-64", name, $signed(act), exp);
    end
  endtask

  // Core stub: done rises 15 edges after the init edge and holds until the next init
  int           stub_cnt = 0;
  logic         stall = 1'b0;
  logic [W-1:0] stub_angle = '0;
  always @(posedge clk) begin
    if (cordic_init) begin
      stub_cnt    <= 15;
      cordic_done <= 1'b0;
      stub_angle  <= cordic_angle;
    end else if (stub_cnt != 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1 && !stall) begin
        cordic_done <= 1'b1;
        cordic_cos  <= q16($cos(ang(stub_angle)));
        cordic_sin  <= q16($sin(ang(stub_angle)));
      end
    end
  end

  exp_t         exp_q[$];
  logic         pref = 1'b0;
  int           n_acc = 0, n_done = 0, rd = 0;
  int           acc_cyc = -100, hs_edge = -100;
  logic         acc_id = 1'b0;
  logic [W-1:0] acc_angle = '0;

  // Reference model: one outstanding job; when both ask, the one not served last wins
  always @(negedge clk) begin : observer
    logic [1:0] exp_rdy;
    logic       g;
    exp_t       e;
    if (!rst_n) begin
      pref = 1'b0;
    end else begin
      exp_rdy = 2'b00;
      g       = 1'b0;
      if (n_acc == n_done && req_valid != 2'b00) begin
        g       = (req_valid == 2'b11) ? pref : req_valid[1];
        exp_rdy = g ? 2'b10 : 2'b01;
      end
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      if (exp_rdy != 2'b00) begin
        acc_angle = g ? req_angle1 : req_angle0;
        e.id      = g;
        e.to      = stall;
        e.cos_v   = stall ? '0 : q16($cos(ang(acc_angle)));
        e.sin_v   = stall ? '0 : q16($sin(ang(acc_angle)));
        e.due     = cyc + 1 + (stall ? TIMEOUT + 1 : NOM_LAT);
        exp_q.push_back(e);
        n_acc++;
        acc_cyc = cyc + 1;
        acc_id  = g;
        pref    = ~g;
      end
    end
  end

  logic         prev_valid = 1'b0;
  logic [W-1:0] h_cos = '0, h_sin = '0;
  logic         h_id = 1'b0, h_to = 1'b0;
  logic         log_id[$];
  logic         log_to[$];
  logic [W-1:0] log_cos[$];
  logic [W-1:0] log_sin[$];

  always @(negedge clk) begin : monitor
    exp_t e;
    #1;
    if (!rst_n) begin
      prev_valid = 1'b0;
      rd         = exp_q.size();
      n_done     = n_acc;
    end else begin
      chk("busy", 32'(busy), 32'((n_acc != n_done) && cyc >= acc_cyc));
      chk("cordic_init", 32'(cordic_init), 32'((n_acc != n_done) && cyc == acc_cyc));
      if (cordic_init) chk("cordic_angle", 32'(cordic_angle), 32'(acc_angle));
      if (res_valid) begin
        if (!prev_valid) begin
          if (rd >= exp_q.size()) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: res_valid with nothing outstanding (cycle %0d)", cyc);
          end else begin
            e = exp_q[rd];
            chk("res_id", 32'(res_id), 32'(e.id));
            chk("res_cos", 32'(res_cos), 32'(e.cos_v));
            chk("res_sin", 32'(res_sin), 32'(e.sin_v));
            chk("res_timeout", 32'(res_timeout), 32'(e.to));
            chk("res_latency", 32'(cyc), 32'(e.due));
          end
          h_cos = res_cos;
          h_sin = res_sin;
          h_id  = res_id;
          h_to  = res_timeout;
        end else begin
          chk("hold_cos", 32'(res_cos), 32'(h_cos));
          chk("hold_sin", 32'(res_sin), 32'(h_sin));
          chk("hold_id", 32'(res_id), 32'(h_id));
          chk("hold_timeout", 32'(res_timeout), 32'(h_to));
        end
        if (res_ready) begin
          if (rd < exp_q.size()) rd++;
          if (n_done < n_acc) n_done++;
          log_id.push_back(res_id);
          log_to.push_back(res_timeout);
          log_cos.push_back(res_cos);
          log_sin.push_back(res_sin);
          hs_edge    = cyc + 1;
          prev_valid = 1'b0;
        end else begin
          prev_valid = 1'b1;
        end
      end else begin
        prev_valid = 1'b0;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int k, input logic [W-1:0] a);
    int start;
    start = n_acc;
    if (k == 0) req_angle0 = a; else req_angle1 = a;
    req_valid[k] = 1'b1;
    for (int i = 0; i < 100 && n_acc == start; i++) tick();
    if (n_acc == start) begin
      checks++;
      errors++;
      $display("FAIL accept_wait: requester %0d not granted within 100 cycles", k);
    end
    req_valid[k] = 1'b0;
  endtask

  task automatic wait_done;
    for (int i = 0; i < 100 && n_done != n_acc; i++) tick();
    if (n_done != n_acc) begin
      checks++;
      errors++;
      $display("FAIL result_wait: %0d results outstanding after 100 cycles", n_acc - n_done);
    end
  endtask

  task automatic do_reset;
    req_valid = 2'b00;
    rst_n     = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  initial begin : stimulus
    int s, a0, last;
    rst_n      = 1'b0;
    req_valid  = 2'b00;
    req_angle0 = '0;
    req_angle1 = '0;
    res_ready  = 1'b1;
    repeat (3) tick();
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_init", 32'(cordic_init), 32'd0);
    chk("rst_angle", 32'(cordic_angle), 32'd0);
    chk("rst_res_cos_sin_id_to", 32'({res_cos, res_sin, res_id, res_timeout} != '0), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single request at pi/4
    issue(0, 18'h0C910);
    wait_done();
    s = log_cos.size() - 1;
    near("pi4_cos", log_cos[s], 'h0B505);
    near("pi4_sin", log_sin[s], 'h0B505);
    chk("pi4_id", 32'(log_id[s]), 32'd0);

    // Both valid straight out of reset: 0 first, then 1
    do_reset();
    s          = log_id.size();
    last       = n_acc;
    req_angle0 = 18'h06488;
    req_angle1 = 18'h336F0;  // -pi/4
    req_valid  = 2'b11;
    for (int i = 0; i < 100 && n_acc < last + 2; i++) begin
      tick();
      if (n_acc != last) begin
        req_valid[acc_id] = 1'b0;
        last = n_acc;
      end
    end
    req_valid = 2'b00;
    wait_done();
    chk("both_count", 32'(log_id.size()), 32'(s + 2));
    if (log_id.size() >= s + 2) begin
      chk("both_first_id", 32'(log_id[s]), 32'd0);
      chk("both_second_id", 32'(log_id[s+1]), 32'd1);
      near("pi8_cos", log_cos[s], 'h0EC83);
      near("pi8_sin", log_sin[s], 'h061F8);
      near("mpi4_cos", log_cos[s+1], 'h0B505);
      near("mpi4_sin", log_sin[s+1], -'h0B505);
    end

    // Fairness with both held valid
    s          = log_id.size();
    req_angle0 = W'($urandom);
    req_angle1 = W'($urandom);
    req_valid  = 2'b11;
    for (int i = 0; i < 300 && log_id.size() < s + 6; i++) tick();
    req_valid = 2'b00;
    wait_done();
    chk("fair_count", 32'(log_id.size()), 32'(s + 6));
    for (int i = 0; i < 6 && s + i < log_id.size(); i++)
      chk("fair_id", 32'(log_id[s+i]), 32'(i % 2));

    // Backpressure: result held for 20 cycles while requester 1 waits
    res_ready = 1'b0;
    issue(0, W'($urandom));
    for (int i = 0; i < 40 && !res_valid; i++) tick();
    chk("bp_valid_seen", 32'(res_valid), 32'd1);
    req_angle1 = W'($urandom);
    req_valid  = 2'b10;
    repeat (20) tick();
    chk("bp_valid_held", 32'(res_valid), 32'd1);
    last      = n_acc;
    res_ready = 1'b1;
    for (int i = 0; i < 10 && n_acc == last; i++) tick();
    req_valid = 2'b00;
    chk("bp_next_accept", 32'(acc_cyc), 32'(hs_edge + 1));
    wait_done();

    // Watchdog, then a normal follow-up
    stall = 1'b1;
    issue(0, W'($urandom));
    wait_done();
    stall = 1'b0;
    chk("wd_timeout", 32'(log_to[log_to.size()-1]), 32'd1);
    issue(1, 18'h0C910);
    wait_done();
    chk("wd_followup_timeout", 32'(log_to[log_to.size()-1]), 32'd0);
    near("wd_followup_cos", log_cos[log_cos.size()-1], 'h0B505);

    // Reset during WAIT
    issue(0, W'($urandom));
    a0 = acc_cyc;
    for (int i = 0; i < 20 && cyc < a0 + 8; i++) tick();
    s = log_id.size();
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_res_valid", 32'(res_valid), 32'd0);
    chk("mid_rst_angle", 32'(cordic_angle), 32'd0);
    chk("mid_rst_res_fields", 32'({res_cos, res_sin, res_id, res_timeout} != '0), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (12) tick();
    chk("mid_rst_no_result", 32'(log_id.size()), 32'(s));
    issue(1, 18'h06488);
    wait_done();
    near("post_rst_cos", log_cos[log_cos.size()-1], 'h0EC83);
    chk("post_rst_id", 32'(log_id[log_id.size()-1]), 32'd1);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      req_valid  = 2'($urandom);
      req_angle0 = W'($urandom);
      req_angle1 = W'($urandom);
      res_ready  = ($urandom_range(3) != 0);
      tick();
    end
    req_valid = 2'b00;
    res_ready = 1'b1;
    wait_done();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
